// File: rtl/wb_size_bridge_p_if.sv
// Wishbone classic bus bundle; master drives the request,
// slave drives read data and terminations.
interface wb_size_bridge_p_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_m;
  logic [DW-1:0]   dat_s;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, err, rty
  );
endinterface

// File: rtl/wb_size_bridge_p.sv
// Wishbone width-down bridge: one wide master access becomes one
// narrow slave cycle per byte chunk that carries select bits.
module wb_size_bridge_p #(
  parameter int HI_DW = 32,
  parameter int LO_DW = 16,
  parameter int AW    = 32
) (
  input  logic               wb_hi_clk_i,
  input  logic               wb_hi_rst_i,
  wb_size_bridge_p_if.slave  wb_hi,
  wb_size_bridge_p_if.master wb_lo
);
  localparam int R   = HI_DW / LO_DW;
  localparam int HB  = HI_DW / 8;
  localparam int LB  = LO_DW / 8;
  localparam int IW  = $clog2(R);
  localparam int LSH = $clog2(LB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [AW-1:0]   adr_q;
  logic            we_q;
  logic [HB-1:0]   sel_q;
  logic [HI_DW-1:0] dat_q;
  logic [HI_DW-1:0] buf_q;
  logic [HI_DW-1:0] buf_d;
  logic [IW-1:0]   idx_q;
  logic            cyc_q;
  logic            stb_q;
  logic            ack_q;
  logic            err_q;
  logic            rty_q;
  logic [AW-1:0]   lo_adr_q;
  logic [LB-1:0]   lo_sel_q;
  logic [LO_DW-1:0] lo_dat_q;
  logic            lo_we_q;

  logic [IW-1:0]   first_idx;
  logic [IW-1:0]   nxt_idx;
  logic            nxt_ok;

  function automatic logic [AW-1:0] chunk_adr(
    input logic [AW-1:0] a,
    input logic [IW-1:0] i
  );
    return (a & ~AW'(HB - 1)) | (AW'(i) << LSH);
  endfunction

  // lowest active chunk of the incoming request, next one above idx
  always_comb begin
    first_idx = '0;
    nxt_idx   = '0;
    nxt_ok    = 1'b0;
    for (int k = R - 1; k >= 0; k--) begin
      if (|wb_hi.sel[k*LB +: LB]) first_idx = IW'(k);
      if ((IW'(k) > idx_q) && (|sel_q[k*LB +: LB])) begin
        nxt_ok  = 1'b1;
        nxt_idx = IW'(k);
      end
    end
  end

  always_comb begin
    buf_d = buf_q;
    for (int b = 0; b < LB; b++) begin
      if (sel_q[int'(idx_q)*LB + b])
        buf_d[(int'(idx_q)*LB + b)*8 +: 8] = wb_lo.dat_s[b*8 +: 8];
    end
  end

  always_ff @(posedge wb_hi_clk_i) begin
    if (!wb_hi_rst_i) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      buf_q    <= '0;
      idx_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      lo_adr_q <= '0;
      lo_sel_q <= '0;
      lo_dat_q <= '0;
      lo_we_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (wb_hi.cyc && wb_hi.stb) begin
            adr_q <= wb_hi.adr;
            we_q  <= wb_hi.we;
            sel_q <= wb_hi.sel;
            dat_q <= wb_hi.dat_m;
            buf_q <= '0;
            if (wb_hi.sel == '0) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q    <= first_idx;
              cyc_q    <= 1'b1;
              stb_q    <= 1'b1;
              lo_we_q  <= wb_hi.we;
              lo_adr_q <= chunk_adr(wb_hi.adr, first_idx);
              lo_sel_q <= wb_hi.sel[first_idx*LB +: LB];
              lo_dat_q <= wb_hi.dat_m[first_idx*LO_DW +: LO_DW];
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          if (!wb_hi.cyc) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= IDLE;
          end else if (wb_lo.err) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (wb_lo.rty) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            rty_q   <= 1'b1;
            state_q <= DONE;
          end else if (wb_lo.ack) begin
            if (!we_q) buf_q <= buf_d;
            if (nxt_ok) begin
              idx_q    <= nxt_idx;
              lo_adr_q <= chunk_adr(adr_q, nxt_idx);
              lo_sel_q <= sel_q[nxt_idx*LB +: LB];
              lo_dat_q <= dat_q[nxt_idx*LO_DW +: LO_DW];
            end else begin
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              ack_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_hi.dat_s = buf_q;
  assign wb_hi.ack   = ack_q;
  assign wb_hi.err   = err_q;
  assign wb_hi.rty   = rty_q;
  assign wb_lo.cyc   = cyc_q;
  assign wb_lo.stb   = stb_q;
  assign wb_lo.we    = lo_we_q;
  assign wb_lo.adr   = lo_adr_q;
  assign wb_lo.sel   = lo_sel_q;
  assign wb_lo.dat_m = lo_dat_q;
endmodule
